// File: rtl/taxi_meter_multi.sv
// Multi-seat taxi meter with a VIP meter, shared wrapping income total and a valid/ready fare port.
// Define TAXI_METER_RAIN_EN to enable the rain surcharge driven by the rainy input.
module taxi_meter_multi #(
  parameter int SEATS      = 4,
  parameter int COST_W     = 32,
  parameter int BASE_FARE  = 10,
  parameter int RATE_MOVE  = 8,
  parameter int RATE_STOP  = 5,
  parameter int VIP_MOVE   = 16,
  parameter int VIP_STOP   = 5,
  parameter int INCOME_CAP = 10000,
  localparam int ID_W      = $clog2(SEATS + 1)
) (
  input  logic                      clock,
  input  logic                      reset_income,
  input  logic                      mode,
  input  logic                      vip_enable,
  input  logic                      rainy,
  input  logic [SEATS-1:0]          seat_occ,
  output logic [SEATS*COST_W-1:0]   seat_cost,
  output logic [COST_W-1:0]         vip_cost,
  output logic [COST_W-1:0]         total_income,
  output logic                      income_wrap,
  output logic                      fare_valid,
  input  logic                      fare_ready,
  output logic [ID_W-1:0]           fare_id,
  output logic [COST_W-1:0]         fare_amount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RIDING = 2'd1,
    SETTLE = 2'd2
  } meter_st_e;

  // Meter index SEATS is the VIP meter; it shares all FSM logic with the seats.
  localparam int N = SEATS + 1;

  meter_st_e         st_q   [N];
  meter_st_e         st_d   [N];
  logic [COST_W-1:0] cost_q [N];
  logic [COST_W-1:0] cost_d [N];

  logic [COST_W-1:0] total_q, total_d;
  logic [COST_W-1:0] charge_sum, sum_d, rate, base_eff, rain_inc;
  logic              wrap_q, wrap_d;
  logic              lock_vld_q, lock_vld_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   win_id;
  logic              win_vld, xfer, rain_on;
  logic [N-1:0]      occ_vec;

`ifdef TAXI_METER_RAIN_EN
  assign rain_on = rainy;
`else
  logic rainy_unused;
  assign rainy_unused = rainy;
  assign rain_on      = 1'b0;
`endif

  assign occ_vec  = {vip_enable, seat_occ};
  assign base_eff = COST_W'(BASE_FARE) + (rain_on ? COST_W'(5) : '0);
  assign rain_inc = COST_W'(rain_on);

  // A presented fare is locked until accepted so a newly settling lower seat cannot preempt it.
  always_comb begin
    win_vld     = lock_vld_q;
    win_id      = lock_id_q;
    fare_amount = '0;
    if (!lock_vld_q) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (st_q[i] == SETTLE) begin
          win_vld = 1'b1;
          win_id  = ID_W'(i);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (win_vld && win_id == ID_W'(i)) fare_amount = cost_q[i];
    end
  end

  assign xfer       = win_vld && fare_ready;
  assign fare_valid = win_vld;
  assign fare_id    = win_id;

  always_comb begin
    charge_sum = '0;
    rate       = '0;
    for (int i = 0; i < N; i++) begin
      st_d[i]   = st_q[i];
      cost_d[i] = cost_q[i];
      if (i == SEATS) begin
        rate = (mode ? COST_W'(VIP_MOVE) : COST_W'(VIP_STOP)) + rain_inc;
      end else begin
        rate = (mode ? COST_W'(RATE_MOVE) + ((i == 0) ? COST_W'(1) : '0)
                     : COST_W'(RATE_STOP)) + rain_inc;
      end
      if (xfer && win_id == ID_W'(i)) begin
        st_d[i]   = IDLE;
        cost_d[i] = '0;
      end else if (i == SEATS || !vip_enable) begin
        case (st_q[i])
          IDLE: begin
            if (occ_vec[i]) begin
              st_d[i]    = RIDING;
              cost_d[i]  = base_eff;
              charge_sum = charge_sum + base_eff;
            end
          end
          RIDING: begin
            if (occ_vec[i]) begin
              cost_d[i]  = cost_q[i] + rate;
              charge_sum = charge_sum + rate;
            end else begin
              st_d[i] = SETTLE;
            end
          end
          default: ;
        endcase
      end
    end
    sum_d      = total_q + charge_sum;
    wrap_d     = sum_d > COST_W'(INCOME_CAP);
    total_d    = wrap_d ? '0 : sum_d;
    lock_vld_d = win_vld && !fare_ready;
    lock_id_d  = win_id;
  end

  always_ff @(posedge clock or posedge reset_income) begin
    if (reset_income) begin
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= IDLE;
        cost_q[i] <= '0;
      end
      total_q    <= '0;
      wrap_q     <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= st_d[i];
        cost_q[i] <= cost_d[i];
      end
      total_q    <= total_d;
      wrap_q     <= wrap_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end

  always_comb begin
    seat_cost = '0;
    for (int i = 0; i < SEATS; i++) seat_cost[i*COST_W +: COST_W] = cost_q[i];
  end

  assign vip_cost     = cost_q[SEATS];
  assign total_income = total_q;
  assign income_wrap  = wrap_q;

endmodule
